// File: rtl/snes_bbus_monitor.sv
// SNES B-bus front end: synchronizes and glitch-filters PA, D and the read/write
// strobes, and emits single-cycle address-change, read-start, write-done and conflict events.
module snes_bbus_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] PA,
  input  logic [7:0] data_in,
  input  logic       PARD_n,
  input  logic       PAWR_n,
  output logic       event_latch,
  output logic [7:0] addr_stable,
  output logic       rd_start,
  output logic [7:0] rd_addr,
  output logic       wr_done,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       bus_err
);

  localparam logic [2:0]  STABLE   = 3'(STABLE_CYCLES);
  localparam logic [17:0] SYNC_RST = 18'h3_0000;

  // Bit layout of each synchronizer stage: {PAWR_n, PARD_n, data_in, PA}
  logic [17:0]            sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] flush_q;

  logic [7:0] s_pa, s_data;
  logic       s_rd, s_wr, run;

  assign s_pa   = sync_q[SYNC_STAGES-1][7:0];
  assign s_data = sync_q[SYNC_STAGES-1][15:8];
  assign s_rd   = sync_q[SYNC_STAGES-1][16];
  assign s_wr   = sync_q[SYNC_STAGES-1][17];
  // Filters stay idle until the chain holds only post-reset samples, so reset fill
  // values can never qualify as a level.
  assign run    = flush_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      flush_q <= '0;
    end else begin
      sync_q[0] <= {PAWR_n, PARD_n, data_in, PA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  function automatic logic [2:0] run_next(input logic hit, input logic [2:0] cnt);
    if (!hit)            return 3'd1;
    else if (cnt >= STABLE) return STABLE;
    else                 return cnt + 3'd1;
  endfunction

  logic [7:0] a_cand;
  logic [2:0] a_cnt, rd_cnt, wr_cnt;
  logic       rd_cand, wr_cand;
  logic [2:0] a_cnt_nxt, rd_cnt_nxt, wr_cnt_nxt;
  logic       a_qual, rd_qual, wr_qual;

  assign a_cnt_nxt  = run_next(s_pa == a_cand, a_cnt);
  assign rd_cnt_nxt = run_next(s_rd == rd_cand, rd_cnt);
  assign wr_cnt_nxt = run_next(s_wr == wr_cand, wr_cnt);
  assign a_qual     = run && (a_cnt_nxt == STABLE);
  assign rd_qual    = run && (rd_cnt_nxt == STABLE);
  assign wr_qual    = run && (wr_cnt_nxt == STABLE);

  logic rd_q, wr_q, rd_q_nxt, wr_q_nxt;
  logic rd_armed, wr_armed, wr_act, conflict_q;
  logic both_low, both_high, rd_fall, wr_fall, wr_rise;
  logic addr_valid;
  logic [7:0] shadow;

  assign rd_q_nxt  = rd_qual ? s_rd : rd_q;
  assign wr_q_nxt  = wr_qual ? s_wr : wr_q;
  assign both_low  = !rd_q_nxt && !wr_q_nxt;
  assign both_high = rd_q_nxt && wr_q_nxt;
  assign rd_fall   = rd_q && !rd_q_nxt;
  assign wr_fall   = wr_q && !wr_q_nxt;
  assign wr_rise   = !wr_q && wr_q_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cand      <= 8'h00;
      a_cnt       <= 3'd0;
      rd_cand     <= 1'b1;
      rd_cnt      <= 3'd0;
      wr_cand     <= 1'b1;
      wr_cnt      <= 3'd0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      rd_armed    <= 1'b0;
      wr_armed    <= 1'b0;
      wr_act      <= 1'b0;
      conflict_q  <= 1'b0;
      addr_valid  <= 1'b0;
      shadow      <= 8'h00;
      event_latch <= 1'b0;
      addr_stable <= 8'h00;
      rd_start    <= 1'b0;
      rd_addr     <= 8'h00;
      wr_done     <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      bus_err     <= 1'b0;
    end else begin
      event_latch <= 1'b0;
      rd_start    <= 1'b0;
      wr_done     <= 1'b0;
      bus_err     <= 1'b0;
      if (run) begin
        a_cand  <= s_pa;
        a_cnt   <= a_cnt_nxt;
        rd_cand <= s_rd;
        rd_cnt  <= rd_cnt_nxt;
        wr_cand <= s_wr;
        wr_cnt  <= wr_cnt_nxt;
        if (!s_wr) shadow <= s_data;
      end
      rd_q <= rd_q_nxt;
      wr_q <= wr_q_nxt;

      if (a_qual && (!addr_valid || s_pa != addr_stable)) begin
        addr_stable <= s_pa;
        addr_valid  <= 1'b1;
        event_latch <= 1'b1;
      end

      // A strobe only counts edges once it has been seen qualified high after reset.
      if (rd_qual && s_rd) rd_armed <= 1'b1;
      if (wr_qual && s_wr) wr_armed <= 1'b1;

      if (rd_fall && rd_armed && !conflict_q && !both_low) begin
        rd_start <= 1'b1;
        rd_addr  <= addr_stable;
      end

      if (wr_fall && wr_armed) begin
        wr_act  <= 1'b1;
        wr_addr <= addr_stable;
      end
      if (wr_rise) begin
        wr_act <= 1'b0;
        if (wr_act && !conflict_q) begin
          wr_done <= 1'b1;
          wr_data <= shadow;
        end
      end

      if (both_low) begin
        conflict_q <= 1'b1;
        wr_act     <= 1'b0;
        if (!conflict_q) bus_err <= 1'b1;
      end else if (both_high) begin
        conflict_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snes_bbus_monitor.sv
// Directed bench for snes_bbus_monitor: address qualification, read, write,
// strobe conflict and reset in the middle of a write.
module tb_snes_bbus_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] PA, data_in;
  logic       PARD_n, PAWR_n;
  logic       event_latch, rd_start, wr_done, bus_err;
  logic [7:0] addr_stable, rd_addr, wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // clock / reset
  always #12.5 clk = ~clk;

  snes_bbus_monitor #(.SYNC_STAGES(2), .STABLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .PA(PA), .data_in(data_in),
    .PARD_n(PARD_n), .PAWR_n(PAWR_n),
    .event_latch(event_latch), .addr_stable(addr_stable),
    .rd_start(rd_start), .rd_addr(rd_addr),
    .wr_done(wr_done), .wr_addr(wr_addr), .wr_data(wr_data),
    .bus_err(bus_err)
  );

  // pulse monitor, sampled away from the active edge
  int ev_n = 0, rd_n = 0, wr_n = 0, err_n = 0;
  logic [7:0] cap_rd_addr = 8'h00, cap_wr_addr = 8'h00, cap_wr_data = 8'h00;

  always @(negedge clk) begin
    if (event_latch) ev_n++;
    if (bus_err) err_n++;
    if (rd_start) begin
      rd_n++;
      cap_rd_addr = rd_addr;
    end
    if (wr_done) begin
      wr_n++;
      cap_wr_addr = wr_addr;
      cap_wr_data = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ev0, rd0, wr0, err0, hits, ev_at;

  initial begin
    rst = 1'b1; PA = 8'h00; data_in = 8'h00; PARD_n = 1'b1; PAWR_n = 1'b1;
    tick(4);
    check("rst_event",  event_latch, 1'b0);
    check("rst_addr",   addr_stable, 8'h00);
    check("rst_pulses", {rd_start, wr_done, bus_err}, 3'b000);

    // first address: event 4 cycles after the first sampling edge
    rst = 1'b0; PA = 8'hFC;
    hits = 0; ev_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (event_latch) begin
        hits++;
        ev_at = i;
      end
    end
    @(negedge clk);
    check("first_ev_latency", ev_at, 4);
    check("first_ev_count", hits, 1);
    check("first_addr", addr_stable, 8'hFC);
    ev0 = ev_n;
    tick(10);
    check("hold_no_event", ev_n - ev0, 0);

    // one-cycle glitches ignored, settle on FD
    ev0 = ev_n;
    PA = 8'hFD; tick(1);
    PA = 8'hFC; tick(1);
    PA = 8'hFD; tick(8);
    check("glitch_ev_count", ev_n - ev0, 1);
    check("glitch_addr", addr_stable, 8'hFD);

    // read at FE
    PA = 8'hFE; tick(6);
    rd0 = rd_n; wr0 = wr_n;
    PARD_n = 1'b0; tick(8);
    PARD_n = 1'b1; tick(6);
    check("rd_count", rd_n - rd0, 1);
    check("rd_addr", cap_rd_addr, 8'hFE);
    check("rd_no_wr", wr_n - wr0, 0);

    // write at 84, data changes late in the strobe
    PA = 8'h84; tick(6);
    rd0 = rd_n; wr0 = wr_n;
    exp_q.push_back(8'hA5);
    PAWR_n = 1'b0; data_in = 8'h11; tick(6);
    data_in = 8'hA5; tick(4);
    PAWR_n = 1'b1; data_in = 8'h00; tick(8);
    check("wr_count", wr_n - wr0, 1);
    check("wr_addr", cap_wr_addr, 8'h84);
    check("wr_data", cap_wr_data, exp_q.pop_front());
    check("wr_no_rd", rd_n - rd0, 0);

    // both strobes low
    rd0 = rd_n; wr0 = wr_n; err0 = err_n;
    PARD_n = 1'b0; PAWR_n = 1'b0; tick(6);
    PARD_n = 1'b1; PAWR_n = 1'b1; tick(8);
    check("conflict_err", err_n - err0, 1);
    check("conflict_no_rd", rd_n - rd0, 0);
    check("conflict_no_wr", wr_n - wr0, 0);
    check("rd_addr_hold", rd_addr, 8'hFE);

    // reset in the middle of a write
    data_in = 8'h77;
    PAWR_n = 1'b0; tick(4);
    rst = 1'b1; tick(3);
    rst = 1'b0; #1;
    check("mid_rst_addr", addr_stable, 8'h00);
    check("mid_rst_wr", {wr_addr, wr_data}, 16'h0000);
    check("mid_rst_rd", rd_addr, 8'h00);
    check("mid_rst_pulses", {event_latch, rd_start, wr_done, bus_err}, 4'b0000);
    @(negedge clk);
    wr0 = wr_n;
    tick(6);
    PAWR_n = 1'b1; tick(8);
    check("mid_rst_no_wr", wr_n - wr0, 0);

    // next full write completes
    PA = 8'h42; tick(6);
    wr0 = wr_n;
    exp_q.push_back(8'h3C);
    data_in = 8'h3C; PAWR_n = 1'b0; tick(6);
    PAWR_n = 1'b1; tick(8);
    check("post_rst_wr_count", wr_n - wr0, 1);
    check("post_rst_wr_addr", cap_wr_addr, 8'h42);
    check("post_rst_wr_data", cap_wr_data, exp_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
